gb_if_responder: RTL
====================

GB_IF_RESPONDER -- requirements
Module: gb_if_responder

Interface
REQ-001 The block SHALL have parameter PORT_WIDTH, default 128, GB/IF data beat width in bits.
REQ-002 The block SHALL have parameter LEN_W, default 10, burst-length field width in beats.
REQ-003 The block SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port GBIF_cfg_val  input  1  GB transfer request valid.
REQ-006 The block SHALL have port IFGB_cfg_rdy  output  1  request accepted when high with GBIF_cfg_val.
REQ-007 The block SHALL have port GBIF_cfg_info  input  4  {class, type[1:0], dir}; dir=1 means IF->GB read, dir=0 means GB->IF write.
REQ-008 The block SHALL have port burst_len_tbl  input  8*LEN_W  beat count per request, indexed by {class, type}.
REQ-009 The block SHALL have port IFGB_rd_val  output  1  read beat valid to GB.
REQ-010 The block SHALL have port GBIF_rd_rdy  input  1  GB ready for read beat.
REQ-011 The block SHALL have port IFGB_rd_data  output  PORT_WIDTH  read beat to GB.
REQ-012 The block SHALL have port GBIF_wr_val  input  1  write beat valid from GB.
REQ-013 The block SHALL have port IFGB_wr_rdy  output  1  block ready for write beat.
REQ-014 The block SHALL have port GBIF_wr_data  input  PORT_WIDTH  write beat from GB.
REQ-015 The block SHALL have ports ext_rd_val input 1, ext_rd_rdy output 1 and ext_rd_data input PORT_WIDTH, forming the off-chip source stream.
REQ-016 The block SHALL have ports ext_wr_val output 1, ext_wr_rdy input 1 and ext_wr_data output PORT_WIDTH, forming the off-chip sink stream.
REQ-017 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-018 The block SHALL have port xfer_done  output  1  one-cycle pulse when the last beat of a burst is handed off.
REQ-019 The block SHALL have port proto_err  output  1  sticky flag for a GB handshake attempted in the wrong state.

Function
REQ-020 FSM states SHALL be IDLE, RD and WR; IFGB_cfg_rdy SHALL equal (state==IDLE).
REQ-021 On cfg handshake the block SHALL latch cfg_info and len = burst_len_tbl[{info[3],info[2:1]}*LEN_W +: LEN_W].
REQ-022 From IDLE the block SHALL enter RD if dir=1 or WR if dir=0; if len==0 it SHALL stay in IDLE and pulse xfer_done next cycle.
REQ-023 Data SHALL pass through one 2-entry FIFO; push when in_val & ~full; pop when out_val & out_rdy; in_rdy SHALL equal ~full, registered only.
REQ-024 RD: FIFO in = ext_rd stream, FIFO out = IFGB_rd stream; ext_rd_rdy SHALL equal state==RD & ~full & fetch_cnt<len.
REQ-025 WR: FIFO in = GBIF_wr stream, FIFO out = ext_wr stream; IFGB_wr_rdy SHALL equal state==WR & ~full & fetch_cnt<len.
REQ-026 Fetch latency: a beat pushed in cycle N SHALL be visible at FIFO output in cycle N+1; with sinks always ready, throughput SHALL be 1 beat/cycle.
REQ-027 fetch_cnt SHALL count pushes and send_cnt SHALL count pops (both LEN_W bits); no over-fetch beyond len.
REQ-028 When the pop with send_cnt==len-1 occurs, the block SHALL pulse xfer_done in that cycle and return to IDLE next cycle; a new cfg SHALL be accepted no earlier than the following cycle.
REQ-029 IFGB_rd_val SHALL be 0 outside RD and ext_wr_val SHALL be 0 outside WR; output data SHALL hold while valid & ~rdy.
REQ-030 proto_err SHALL set on GBIF_wr_val while not in WR, or on GBIF_cfg_val with cfg_info change while ~IFGB_cfg_rdy, and SHALL clear only on reset.
REQ-031 The GB side SHALL never drop valid before rdy; a stalled sink SHALL stall the source with no data loss.

Reset
REQ-032 Asynchronous rst_n low SHALL force state IDLE, FIFO empty, counters 0, busy=0, xfer_done=0, proto_err=0, all valid/rdy outputs 0 except IFGB_cfg_rdy=1 after release; data outputs 0.
REQ-033 Reset mid-burst SHALL discard buffered beats; no partial-burst completion SHALL be signalled.

Structure
REQ-034 A shared package SHALL hold the state enum, cfg_info field positions, and type codes (WEI=0, WFLG=1, ACT=2, AFLG=3).
REQ-035 The 2-entry FIFO SHALL be a sub-module named gb_if_fifo2, parameterised by PORT_WIDTH.

Verification
REQ-036 cfg_info={1,2,1}, len=4, ext and GB always ready -> 4 beats on IFGB_rd_data in order over 4 consecutive cycles, xfer_done with 4th beat.
REQ-037 RD len=3 with GBIF_rd_rdy low for 5 cycles after beat 1 -> ext_rd_rdy drops after FIFO fills, no loss or duplication, exactly 3 beats delivered.
REQ-038 cfg_info={1,0,0}, len=2 -> 2 GB write beats appear on ext_wr_data; IFGB_wr_rdy drops after the 2nd beat.
REQ-039 len=0 request -> xfer_done pulses 1 cycle later, no beats, and IFGB_cfg_rdy stays 1.
REQ-040 GBIF_wr_val pulsed during RD -> proto_err=1 and sticky; rst_n asserted mid-RD -> all outputs at reset values, FIFO empty.

Source files
------------

// File: rtl/gb_if_responder_pkg.sv
// Shared definitions for the GB/IF responder: FSM states, cfg_info layout, type codes.
package gb_if_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    localparam int CFG_DIR      = 0;
    localparam int CFG_TYPE_LSB = 1;
    localparam int CFG_TYPE_MSB = 2;
    localparam int CFG_CLASS    = 3;

    localparam logic [1:0] TYPE_WEI  = 2'd0;
    localparam logic [1:0] TYPE_WFLG = 2'd1;
    localparam logic [1:0] TYPE_ACT  = 2'd2;
    localparam logic [1:0] TYPE_AFLG = 2'd3;

endpackage

// File: rtl/gb_if_responder_if.sv
// GB-side handshake bundle: cfg request, read beat stream and write beat stream.
interface gb_if_responder_if #(
    parameter int PORT_WIDTH = 128
);
    logic                  GBIF_cfg_val;
    logic                  IFGB_cfg_rdy;
    logic [3:0]            GBIF_cfg_info;
    logic                  IFGB_rd_val;
    logic                  GBIF_rd_rdy;
    logic [PORT_WIDTH-1:0] IFGB_rd_data;
    logic                  GBIF_wr_val;
    logic                  IFGB_wr_rdy;
    logic [PORT_WIDTH-1:0] GBIF_wr_data;

    modport master (
        output GBIF_cfg_val, GBIF_cfg_info, GBIF_rd_rdy, GBIF_wr_val, GBIF_wr_data,
        input  IFGB_cfg_rdy, IFGB_rd_val, IFGB_rd_data, IFGB_wr_rdy
    );

    modport slave (
        input  GBIF_cfg_val, GBIF_cfg_info, GBIF_rd_rdy, GBIF_wr_val, GBIF_wr_data,
        output IFGB_cfg_rdy, IFGB_rd_val, IFGB_rd_data, IFGB_wr_rdy
    );
endinterface

// File: rtl/gb_if_fifo2.sv
// Two-entry beat buffer; in_rdy comes straight from the registered full flag.
module gb_if_fifo2 #(
    parameter int PORT_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_val,
    input  logic [PORT_WIDTH-1:0] in_data,
    output logic                  in_rdy,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [PORT_WIDTH-1:0] out_data
);
    logic [PORT_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic                  full;
    logic                  push;
    logic                  pop;

    assign full     = (count == 2'd2);
    assign in_rdy   = ~full;
    assign out_val  = (count != 2'd0);
    assign out_data = mem[rd_ptr];
    assign push     = in_val & ~full;
    assign pop      = out_val & out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/gb_if_responder.sv
// GB/IF burst responder: accepts a cfg request, then moves len beats ext->GB (RD) or GB->ext (WR).
module gb_if_responder
    import gb_if_responder_pkg::*;
#(
    parameter int PORT_WIDTH = 128,
    parameter int LEN_W      = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gb_if_responder_if.slave      gb,
    input  logic [8*LEN_W-1:0]    burst_len_tbl,
    input  logic                  ext_rd_val,
    output logic                  ext_rd_rdy,
    input  logic [PORT_WIDTH-1:0] ext_rd_data,
    output logic                  ext_wr_val,
    input  logic                  ext_wr_rdy,
    output logic [PORT_WIDTH-1:0] ext_wr_data,
    output logic                  busy,
    output logic                  xfer_done,
    output logic                  proto_err
);
    state_t                state;
    logic [3:0]            info_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      fetch_cnt;
    logic [LEN_W-1:0]      send_cnt;
    logic                  zero_done_q;
    logic                  proto_err_q;

    logic                  cfg_rdy;
    logic                  cfg_hs;
    logic [2:0]            tbl_idx;
    logic [LEN_W-1:0]      cfg_len;
    logic                  fetch_ok;
    logic                  fifo_in_val;
    logic [PORT_WIDTH-1:0] fifo_in_data;
    logic                  fifo_in_rdy;
    logic                  fifo_out_val;
    logic                  fifo_out_rdy;
    logic [PORT_WIDTH-1:0] fifo_out_data;
    logic                  pop;
    logic                  last_pop;
    logic                  proto_hit;

    assign cfg_rdy  = (state == IDLE);
    assign cfg_hs   = gb.GBIF_cfg_val & cfg_rdy;
    assign tbl_idx  = {gb.GBIF_cfg_info[CFG_CLASS], gb.GBIF_cfg_info[CFG_TYPE_MSB:CFG_TYPE_LSB]};
    assign cfg_len  = burst_len_tbl[int'(tbl_idx)*LEN_W +: LEN_W];
    assign fetch_ok = (fetch_cnt < len_q);

    // Source/sink steering; the idle direction sees neither valid nor ready.
    assign fifo_in_val  = fetch_ok & (((state == RD) & ext_rd_val) | ((state == WR) & gb.GBIF_wr_val));
    assign fifo_in_data = (state == RD) ? ext_rd_data : gb.GBIF_wr_data;
    assign fifo_out_rdy = ((state == RD) & gb.GBIF_rd_rdy) | ((state == WR) & ext_wr_rdy);

    gb_if_fifo2 #(.PORT_WIDTH(PORT_WIDTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_val   (fifo_in_val),
        .in_data  (fifo_in_data),
        .in_rdy   (fifo_in_rdy),
        .out_val  (fifo_out_val),
        .out_rdy  (fifo_out_rdy),
        .out_data (fifo_out_data)
    );

    assign pop      = fifo_out_val & fifo_out_rdy;
    assign last_pop = pop & (send_cnt == len_q - LEN_W'(1));

    assign gb.IFGB_cfg_rdy = cfg_rdy;
    assign ext_rd_rdy      = (state == RD) & fifo_in_rdy & fetch_ok;
    assign gb.IFGB_wr_rdy  = (state == WR) & fifo_in_rdy & fetch_ok;
    assign gb.IFGB_rd_val  = (state == RD) & fifo_out_val;
    assign ext_wr_val      = (state == WR) & fifo_out_val;
    assign gb.IFGB_rd_data = gb.IFGB_rd_val ? fifo_out_data : '0;
    assign ext_wr_data     = ext_wr_val ? fifo_out_data : '0;

    assign busy      = (state != IDLE);
    assign xfer_done = last_pop | zero_done_q;
    assign proto_err = proto_err_q;

    assign proto_hit = (gb.GBIF_wr_val & (state != WR)) |
                       (gb.GBIF_cfg_val & ~cfg_rdy & (gb.GBIF_cfg_info != info_q));

    // state | meaning
    // IDLE  | waiting for a cfg request; cfg_rdy high
    // RD    | ext_rd -> FIFO -> IFGB_rd until len beats sent
    // WR    | GBIF_wr -> FIFO -> ext_wr until len beats sent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            info_q      <= '0;
            len_q       <= '0;
            fetch_cnt   <= '0;
            send_cnt    <= '0;
            zero_done_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            zero_done_q <= 1'b0;
            if (fifo_in_val & fifo_in_rdy)
                fetch_cnt <= fetch_cnt + LEN_W'(1);
            if (pop)
                send_cnt <= send_cnt + LEN_W'(1);
            if (proto_hit)
                proto_err_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (cfg_hs) begin
                        info_q    <= gb.GBIF_cfg_info;
                        len_q     <= cfg_len;
                        fetch_cnt <= '0;
                        send_cnt  <= '0;
                        if (cfg_len == '0)
                            zero_done_q <= 1'b1;
                        else
                            state <= gb.GBIF_cfg_info[CFG_DIR] ? RD : WR;
                    end
                end
                RD, WR: begin
                    if (last_pop)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
